fu_issue_scheduler: RTL

- Picks at most one instruction per cycle from NUM_REQ issue-queue candidates and grants it to one of three functional units.
- Functional units: ALU (1 cycle), pipelined multiplier (MUL_LAT), iterative divider (DIV_LAT, not pipelined).
- Arbitration is oldest-first by ROB age relative to the ROB head.
- Reserves the single shared complete/writeback port ahead of time so that no two FUs ever complete in the same cycle.
- Sits between issue_queue select outputs and the execute units; drives the complete-stage writeback mux select.

---
 rtl/fu_issue_scheduler_pkg.sv | 17 +
 rtl/fu_issue_scheduler_if.sv | 30 +++
 rtl/fu_issue_scheduler_age_select.sv | 35 +++
 rtl/fu_issue_scheduler.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fu_issue_scheduler_pkg.sv
// Shared types and latency constants for the functional-unit issue scheduler.
package ooo_sched_pkg;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MUL  = 2'd1,
        FU_DIV  = 2'd2,
        FU_RSVD = 2'd3
    } fu_class_t;

    localparam int ALU_LAT = 1;

    function automatic int max_lat(int mul_lat, int div_lat);
        return (mul_lat > div_lat) ? mul_lat : div_lat;
    endfunction

endpackage

// File: rtl/fu_issue_scheduler_if.sv
// Issue-queue / scheduler / writeback-mux handshake bundle.
interface fu_issue_scheduler_if #(
    parameter int NUM_REQ      = 4,
    parameter int ROB_IDX_BITS = 4
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                           flush;
    logic [NUM_REQ-1:0]             req_valid;
    logic [2*NUM_REQ-1:0]           req_fu;
    logic [ROB_IDX_BITS*NUM_REQ-1:0] req_rob_idx;
    logic [ROB_IDX_BITS-1:0]        rob_head;
    logic [NUM_REQ-1:0]             grant;
    logic                           grant_valid;
    logic [IDX_W-1:0]               grant_idx;
    logic [1:0]                     grant_fu;
    logic                           wb_valid;
    logic [1:0]                     wb_fu;
    logic                           div_busy;

    modport master (
        output flush, req_valid, req_fu, req_rob_idx, rob_head,
        input  grant, grant_valid, grant_idx, grant_fu, wb_valid, wb_fu, div_busy
    );

    modport slave (
        input  flush, req_valid, req_fu, req_rob_idx, rob_head,
        output grant, grant_valid, grant_idx, grant_fu, wb_valid, wb_fu, div_busy
    );
endinterface

// File: rtl/fu_issue_scheduler_age_select.sv
// Combinational oldest-first picker: smallest (rob_idx - head) among eligible, ties to lowest slot.
module age_select #(
    parameter int NUM_REQ      = 4,
    parameter int ROB_IDX_BITS = 4,
    localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]              elig,
    input  logic [ROB_IDX_BITS*NUM_REQ-1:0] rob_idx,
    input  logic [ROB_IDX_BITS-1:0]         head,
    output logic [NUM_REQ-1:0]              onehot,
    output logic [IDX_W-1:0]                idx,
    output logic                            found
);
    logic [ROB_IDX_BITS-1:0] age [NUM_REQ];
    logic [ROB_IDX_BITS-1:0] best_age;

    // Modular subtraction makes indices that wrapped past the head count as younger.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
        assign age[i] = rob_idx[i*ROB_IDX_BITS +: ROB_IDX_BITS] - head;
    end

    always_comb begin
        found    = 1'b0;
        idx      = '0;
        best_age = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (elig[i] && (!found || age[i] < best_age)) begin
                found    = 1'b1;
                best_age = age[i];
                idx      = IDX_W'(i);
            end
        end
        onehot = found ? (NUM_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/fu_issue_scheduler.sv
// Grants one candidate per cycle to ALU/MUL/DIV, pre-booking the shared writeback port
// so that no two units ever complete in the same cycle.
module fu_issue_scheduler
    import ooo_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ROB_IDX_BITS = 4,
    parameter int MUL_LAT      = 3,
    parameter int DIV_LAT      = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    fu_issue_scheduler_if.slave bus
);
    localparam int MAX_LAT = max_lat(MUL_LAT, DIV_LAT);
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int CNT_W   = $clog2(DIV_LAT);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [MAX_LAT-1:0]      resv;
    logic [MAX_LAT-1:0][1:0] resv_fu;
    logic [CNT_W-1:0]        div_cnt;

    logic [MAX_LAT:0]        resv_ext;
    logic [MAX_LAT:0][1:0]   resv_fu_ext;
    logic [MAX_LAT-1:0]      resv_nxt;
    logic [MAX_LAT-1:0][1:0] resv_fu_nxt;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic               grant_v;
    fu_class_t          gfu;
    logic [LAT_W-1:0]   grant_lat;
    logic               wb_v;

    function automatic logic [LAT_W-1:0] lat_of(fu_class_t cls);
        case (cls)
            FU_ALU:  lat_of = LAT_W'(ALU_LAT);
            FU_MUL:  lat_of = LAT_W'(MUL_LAT);
            FU_DIV:  lat_of = LAT_W'(DIV_LAT);
            default: lat_of = '0;
        endcase
    endfunction

    // Slot MAX_LAT is always free, so the longest-latency class never conflicts.
    assign resv_ext    = {1'b0, resv};
    assign resv_fu_ext = {2'b00, resv_fu};

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cand
        fu_class_t        cls;
        logic [LAT_W-1:0] lat;
        assign cls = fu_class_t'(bus.req_fu[2*i +: 2]);
        assign lat = lat_of(cls);
        assign elig[i] = bus.req_valid[i] && (cls != FU_RSVD) && !bus.flush
                         && !resv_ext[lat] && ((cls != FU_DIV) || (div_cnt == '0));
    end

    age_select #(
        .NUM_REQ      (NUM_REQ),
        .ROB_IDX_BITS (ROB_IDX_BITS)
    ) u_age_select (
        .elig    (elig),
        .rob_idx (bus.req_rob_idx),
        .head    (bus.rob_head),
        .onehot  (sel_onehot),
        .idx     (sel_idx),
        .found   (sel_found)
    );

    assign grant_v   = rst_n && sel_found;
    assign gfu       = grant_v ? fu_class_t'(bus.req_fu[2*sel_idx +: 2]) : FU_ALU;
    assign grant_lat = lat_of(gfu);

    assign bus.grant       = grant_v ? sel_onehot : '0;
    assign bus.grant_valid = grant_v;
    assign bus.grant_idx   = grant_v ? sel_idx : '0;
    assign bus.grant_fu    = gfu;

    // Shift the reservation ring toward slot 0 and book slot L-1 for this grant.
    always_comb begin
        resv_nxt    = '0;
        resv_fu_nxt = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            if (grant_v && (grant_lat == LAT_W'(k + 1))) begin
                resv_nxt[k]    = 1'b1;
                resv_fu_nxt[k] = gfu;
            end else begin
                resv_nxt[k]    = resv_ext[k+1];
                resv_fu_nxt[k] = resv_fu_ext[k+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv    <= '0;
            resv_fu <= '0;
            div_cnt <= '0;
        end else if (bus.flush) begin
            resv    <= '0;
            resv_fu <= '0;
            div_cnt <= '0;
        end else begin
            resv    <= resv_nxt;
            resv_fu <= resv_fu_nxt;
            if (grant_v && (gfu == FU_DIV)) begin
                div_cnt <= CNT_W'(DIV_LAT - 1);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

    assign wb_v         = resv[0] && !bus.flush;
    assign bus.wb_valid = wb_v;
    assign bus.wb_fu    = wb_v ? resv_fu[0] : 2'b00;
    assign bus.div_busy = (div_cnt != '0);
endmodule
